// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and comparator-side bus for the serial magnitude comparator.
// The slave modport is the sequencer; the master modport is its environment.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;
  logic [3:0]       cmp_a;
  logic [3:0]       cmp_b;
  logic             cmp_cas_lt;
  logic             cmp_cas_gt;
  logic             cmp_cas_eq;
  logic             cmp_lt;
  logic             cmp_gt;
  logic             cmp_eq;

  modport slave (
    input  start, a, b, cmp_lt, cmp_gt, cmp_eq,
    output busy, done, lt, gt, eq,
    output cmp_a, cmp_b, cmp_cas_lt, cmp_cas_gt, cmp_cas_eq
  );

  modport master (
    output start, a, b, cmp_lt, cmp_gt, cmp_eq,
    input  busy, done, lt, gt, eq,
    input  cmp_a, cmp_b, cmp_cas_lt, cmp_cas_gt, cmp_cas_eq
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Nibble-serial unsigned magnitude compare, LS nibble first, driving an
// external combinational 4-bit cascadable comparator.
//
// state | meaning
// IDLE  | waiting for start; previous result held
// RUN   | one nibble per cycle through the external comparator
// DONE  | one-cycle done pulse, result valid
module serial_magnitude_comparator #(
  parameter int WIDTH = 16
) (
  input logic                          clk,
  input logic                          rst_n,
  serial_magnitude_comparator_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_cas_lt;
  logic             r_cas_gt;
  logic             r_cas_eq;
  logic             r_lt;
  logic             r_gt;
  logic             r_eq;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic             w_last;

  assign w_last = (r_cnt == LAST_CNT);
  assign w_a_sh = r_a >> {r_cnt, 2'b00};
  assign w_b_sh = r_b >> {r_cnt, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.cmp_a      = 4'h0;
    bus.cmp_b      = 4'h0;
    bus.cmp_cas_lt = r_cas_lt;
    bus.cmp_cas_gt = r_cas_gt;
    bus.cmp_cas_eq = r_cas_eq;
    bus.lt         = r_lt;
    bus.gt         = r_gt;
    bus.eq         = r_eq;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_nxt = RUN;
      end
      RUN: begin
        bus.busy  = 1'b1;
        bus.cmp_a = w_a_sh[3:0];
        bus.cmp_b = w_b_sh[3:0];
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Comparator result is taken as-is, even if not one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_cas_lt <= 1'b0;
      r_cas_gt <= 1'b0;
      r_cas_eq <= 1'b1;
      r_lt     <= 1'b0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_cnt    <= '0;
            r_cas_lt <= 1'b0;
            r_cas_gt <= 1'b0;
            r_cas_eq <= 1'b1;
          end
        end
        RUN: begin
          r_cas_lt <= bus.cmp_lt;
          r_cas_gt <= bus.cmp_gt;
          r_cas_eq <= bus.cmp_eq;
          if (w_last) begin
            r_cnt <= '0;
            r_lt  <= bus.cmp_lt;
            r_gt  <= bus.cmp_gt;
            r_eq  <= bus.cmp_eq;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (16-bit and 4-bit builds),
// with a behavioural 4-bit cascadable comparator closing the loop.
module tb_serial_magnitude_comparator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator_if #(.WIDTH(16)) bus16 ();
  serial_magnitude_comparator_if #(.WIDTH(4))  bus4 ();

  serial_magnitude_comparator #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  serial_magnitude_comparator #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  // external cascadable comparator: unequal nibble decides, equal passes cascade
  always_comb begin
    bus16.cmp_lt = 1'b0;
    bus16.cmp_gt = 1'b0;
    bus16.cmp_eq = 1'b0;
    if (bus16.cmp_a < bus16.cmp_b)      bus16.cmp_lt = 1'b1;
    else if (bus16.cmp_a > bus16.cmp_b) bus16.cmp_gt = 1'b1;
    else {bus16.cmp_lt, bus16.cmp_gt, bus16.cmp_eq} =
           {bus16.cmp_cas_lt, bus16.cmp_cas_gt, bus16.cmp_cas_eq};
  end

  always_comb begin
    bus4.cmp_lt = 1'b0;
    bus4.cmp_gt = 1'b0;
    bus4.cmp_eq = 1'b0;
    if (bus4.cmp_a < bus4.cmp_b)      bus4.cmp_lt = 1'b1;
    else if (bus4.cmp_a > bus4.cmp_b) bus4.cmp_gt = 1'b1;
    else {bus4.cmp_lt, bus4.cmp_gt, bus4.cmp_eq} =
           {bus4.cmp_cas_lt, bus4.cmp_cas_gt, bus4.cmp_cas_eq};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_res is {lt,gt,eq}; exp_cas_lt bit k is cmp_cas_lt in busy cycle k
  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input int stray_at, input logic [2:0] exp_res,
                       input logic [3:0] exp_cas_lt);
    logic [3:0] hist;
    logic       seen;
    int         k;
    bus16.start = 1'b1;
    bus16.a     = ta;
    bus16.b     = tb_v;
    tick();
    bus16.start = 1'b0;
    bus16.a     = ~ta;
    bus16.b     = ~tb_v;
    hist = 4'h0;
    seen = 1'b0;
    k    = 0;
    while (k < 20 && !seen) begin
      if (bus16.done) begin
        seen = 1'b1;
      end else begin
        if (k < 4) hist[k] = bus16.cmp_cas_lt;
        chk({tag, "_busy"}, 32'(bus16.busy), 32'd1);
        if (k == stray_at) begin
          bus16.start = 1'b1;
          bus16.a     = 16'h0000;
          bus16.b     = 16'hFFFF;
        end else begin
          bus16.start = 1'b0;
        end
        tick();
        k++;
      end
    end
    bus16.start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(k), 32'd4);
    chk({tag, "_busy_in_done"}, 32'(bus16.busy), 32'd0);
    chk({tag, "_cas_lt_hist"}, 32'(hist), 32'(exp_cas_lt));
    chk({tag, "_result"}, 32'({bus16.lt, bus16.gt, bus16.eq}), 32'(exp_res));
    chk({tag, "_onehot"}, 32'($countones({bus16.lt, bus16.gt, bus16.eq})), 32'd1);
    tick();
    chk({tag, "_done_once"}, 32'(bus16.done), 32'd0);
    chk({tag, "_result_held"}, 32'({bus16.lt, bus16.gt, bus16.eq}), 32'(exp_res));
  endtask

  initial begin
    int n_done;
    int first_k;
    int prev_k;
    bus16.start = 1'b0;
    bus16.a     = '0;
    bus16.b     = '0;
    bus4.start  = 1'b0;
    bus4.a      = '0;
    bus4.b      = '0;

    tick();
    tick();
    chk("rst_busy", 32'(bus16.busy), 32'd0);
    chk("rst_done", 32'(bus16.done), 32'd0);
    chk("rst_result", 32'({bus16.lt, bus16.gt, bus16.eq}), 32'd0);
    chk("rst_cascade", 32'({bus16.cmp_cas_lt, bus16.cmp_cas_gt, bus16.cmp_cas_eq}), 32'b001);
    chk("rst_cmp_ab", 32'({bus16.cmp_a, bus16.cmp_b}), 32'd0);
    #4 rst_n = 1'b1;
    tick();

    run16("eq1234", 16'h1234, 16'h1234, -1, 3'b001, 4'b0000);
    run16("gt8000", 16'h8000, 16'h7FFF, -1, 3'b010, 4'b1110);
    run16("lt00F0", 16'h00F0, 16'h00F1, -1, 3'b100, 4'b1110);
    run16("stray",  16'h0005, 16'h0003,  1, 3'b010, 4'b0000);

    // abort mid-compare with reset
    bus16.start = 1'b1;
    bus16.a     = 16'h0001;
    bus16.b     = 16'h0002;
    tick();
    bus16.start = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    chk("abort_busy", 32'(bus16.busy), 32'd0);
    chk("abort_done", 32'(bus16.done), 32'd0);
    chk("abort_result", 32'({bus16.lt, bus16.gt, bus16.eq}), 32'd0);
    chk("abort_cascade", 32'({bus16.cmp_cas_lt, bus16.cmp_cas_gt, bus16.cmp_cas_eq}), 32'b001);
    #2 rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus16.done) n_done++;
    end
    chk("abort_no_stale_done", 32'(n_done), 32'd0);
    run16("after_rst", 16'hFFFF, 16'h0000, -1, 3'b010, 4'b0000);

    // 4-bit build, start held high: done every 3 cycles
    bus4.a     = 4'h3;
    bus4.b     = 4'h3;
    bus4.start = 1'b1;
    n_done  = 0;
    first_k = -1;
    prev_k  = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) chk("w4_busy", 32'(bus4.busy), 32'd1);
      if (bus4.done) begin
        n_done++;
        if (first_k < 0) begin
          first_k = k;
          chk("w4_eq", 32'({bus4.lt, bus4.gt, bus4.eq}), 32'b001);
        end else begin
          chk("w4_interval", 32'(k - prev_k), 32'd3);
        end
        prev_k = k;
      end
    end
    bus4.start = 1'b0;
    chk("w4_first_done", 32'(first_k), 32'd1);
    chk("w4_done_count", 32'(n_done), 32'd4);
    tick();
    tick();
    bus4.a     = 4'h2;
    bus4.b     = 4'h9;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick();
    chk("w4_lt_done", 32'(bus4.done), 32'd1);
    chk("w4_lt_result", 32'({bus4.lt, bus4.gt, bus4.eq}), 32'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
